// File: rtl/pid_core.sv
// pid_core: fixed-point PID compute stage.
//
// On each accepted sample strobe the gains (signed Q7.8) and the
// setpoint/feedback pair are latched, then a small FSM walks through
// error/integrator/derivative update, three multiply-accumulate steps on a
// single shared multiplier, and a final shift-and-saturate to a 16-bit
// signed control output.
//
// Ports:
//   clk_in        in   1   system clock (sole domain)
//   reset         in   1   synchronous, active-high reset
//   kp, ki, kd    in  16   signed Q7.8 gains
//   setpoint      in  16   signed target value
//   feedback      in  16   signed measured value
//   sample_valid  in   1   one-cycle request to compute a new output
//   clear_integ   in   1   zero integrator and previous error (IDLE only)
//   u             out 16   signed control output, held between updates
//   u_valid       out  1   one-cycle pulse when u updates
//   busy          out  1   high while a computation is in flight
module pid_core #(
    parameter int FRAC      = 8,
    parameter int INTEG_LIM = 8192
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    input  logic [15:0] setpoint,
    input  logic [15:0] feedback,
    input  logic        sample_valid,
    input  logic        clear_integ,
    output logic [15:0] u,
    output logic        u_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    localparam logic signed [16:0] S17_MAX = 17'sh07FFF;
    localparam logic signed [16:0] S17_MIN = 17'sh18000;
    localparam logic signed [33:0] S34_MAX = 34'sh0_0000_7FFF;
    localparam logic signed [33:0] S34_MIN = 34'sh3_FFFF_8000;
    localparam logic signed [16:0] LIM_POS = 17'(INTEG_LIM);
    localparam logic signed [16:0] LIM_NEG = -LIM_POS;

    // Saturate a 17-bit signed value to the 16-bit signed range.
    function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
        logic signed [15:0] r;
        if (v > S17_MAX) begin
            r = 16'sh7FFF;
        end else if (v < S17_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Saturate a 34-bit signed value to the 16-bit signed range.
    function automatic logic signed [15:0] sat34(input logic signed [33:0] v);
        logic signed [15:0] r;
        if (v > S34_MAX) begin
            r = 16'sh7FFF;
        end else if (v < S34_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Clamp a 17-bit integrator sum to +/-INTEG_LIM; result fits 16 bits.
    function automatic logic signed [15:0] clamp_integ(input logic signed [16:0] v);
        logic signed [16:0] r;
        if (v > LIM_POS) begin
            r = LIM_POS;
        end else if (v < LIM_NEG) begin
            r = LIM_NEG;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

    state_t             state_r;
    logic signed [15:0] kp_r;
    logic signed [15:0] ki_r;
    logic signed [15:0] kd_r;
    logic signed [15:0] sp_r;
    logic signed [15:0] fb_r;
    logic signed [15:0] e_r;
    logic signed [15:0] e_prev_r;
    logic signed [15:0] integ_r;
    logic signed [15:0] d_r;
    logic signed [33:0] acc_r;
    logic [15:0]        u_r;
    logic               u_valid_r;
    logic               busy_r;

    logic signed [16:0] diff_s;
    logic signed [15:0] e_s;
    logic signed [16:0] integ_sum_s;
    logic signed [15:0] integ_next_s;
    logic signed [16:0] d_diff_s;
    logic signed [15:0] d_s;
    logic signed [15:0] mul_a_s;
    logic signed [15:0] mul_b_s;
    logic signed [31:0] prod_s;
    logic signed [33:0] prod_ext_s;
    logic signed [33:0] acc_shift_s;
    logic signed [15:0] u_sat_s;

    // Error, integrator and derivative terms; all widened to 17 bits so the
    // subtraction/addition cannot wrap before saturation.
    always_comb begin
        diff_s       = $signed({sp_r[15], sp_r}) - $signed({fb_r[15], fb_r});
        e_s          = sat17(diff_s);
        integ_sum_s  = $signed({integ_r[15], integ_r}) + $signed({e_s[15], e_s});
        integ_next_s = clamp_integ(integ_sum_s);
        d_diff_s     = $signed({e_s[15], e_s}) - $signed({e_prev_r[15], e_prev_r});
        d_s          = sat17(d_diff_s);
    end

    // Operand select for the single shared multiplier, keyed by MAC step.
    always_comb begin
        mul_a_s = kp_r;
        mul_b_s = e_r;
        case (state_r)
            ST_MUL_I: begin
                mul_a_s = ki_r;
                mul_b_s = integ_r;
            end
            ST_MUL_D: begin
                mul_a_s = kd_r;
                mul_b_s = d_r;
            end
            default: begin
                mul_a_s = kp_r;
                mul_b_s = e_r;
            end
        endcase
    end

    // Shared multiplier and output scaling (arithmetic shift floors toward -inf).
    always_comb begin
        prod_s      = mul_a_s * mul_b_s;
        prod_ext_s  = {{2{prod_s[31]}}, prod_s};
        acc_shift_s = acc_r >>> FRAC;
        u_sat_s     = sat34(acc_shift_s);
    end

    // Sequencing FSM with all state and outputs registered; reset aborts any
    // computation in flight without producing a result.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            kp_r      <= 16'sd0;
            ki_r      <= 16'sd0;
            kd_r      <= 16'sd0;
            sp_r      <= 16'sd0;
            fb_r      <= 16'sd0;
            e_r       <= 16'sd0;
            e_prev_r  <= 16'sd0;
            integ_r   <= 16'sd0;
            d_r       <= 16'sd0;
            acc_r     <= 34'sd0;
            u_r       <= 16'd0;
            u_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            u_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Clear lands before the ERR step of a coincident sample,
                    // so that sample starts from zero history.
                    if (clear_integ) begin
                        integ_r  <= 16'sd0;
                        e_prev_r <= 16'sd0;
                    end
                    if (sample_valid) begin
                        kp_r    <= $signed(kp);
                        ki_r    <= $signed(ki);
                        kd_r    <= $signed(kd);
                        sp_r    <= $signed(setpoint);
                        fb_r    <= $signed(feedback);
                        state_r <= ST_ERR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ERR: begin
                    e_r      <= e_s;
                    integ_r  <= integ_next_s;
                    d_r      <= d_s;
                    e_prev_r <= e_s;
                    state_r  <= ST_MUL_P;
                end
                ST_MUL_P: begin
                    acc_r   <= prod_ext_s;
                    state_r <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    acc_r   <= acc_r + prod_ext_s;
                    state_r <= ST_MUL_D;
                end
                ST_MUL_D: begin
                    acc_r   <= acc_r + prod_ext_s;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    u_r       <= u_sat_s;
                    u_valid_r <= 1'b1;
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign u       = u_r;
    assign u_valid = u_valid_r;
    assign busy    = busy_r;

endmodule

// File: doc/pid_core.md
Name: pid_core

Overview:
- Fixed-point PID compute stage downstream of the gain memory.
- Consumes the Kp/Ki/Kd gain registers loaded over UART, plus a setpoint/feedback pair, on each sample strobe.
- Produces a saturated 16-bit control output with a one-cycle valid pulse.
- Uses a single time-shared multiplier sequenced by a small FSM.

Parameters:
- FRAC, 8: fractional bits of the gains (Q7.8 signed); product shift amount.
- INTEG_LIM, 8192: symmetric clamp magnitude for the integrator, range ±INTEG_LIM.

Ports:
- clk_in  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- kp  in  16  proportional gain, signed Q7.8.
- ki  in  16  integral gain, signed Q7.8.
- kd  in  16  derivative gain, signed Q7.8.
- setpoint  in  16  signed target value.
- feedback  in  16  signed measured value.
- sample_valid  in  1  one-cycle request to compute a new output.
- clear_integ  in  1  zero the integrator and the previous error.
- u  out  16  signed control output, held between updates.
- u_valid  out  1  one-cycle pulse when u updates.
- busy  out  1  high while a computation is in flight.

Behaviour:
- Clocking: one clock (clk_in); reset is synchronous, active-high. All state changes on the rising edge of clk_in.
- Reset values: u=0, u_valid=0, busy=0, state=IDLE, integ=0, e_prev=0, acc=0.
- Reset has priority over everything, including mid-computation; an in-flight result is discarded and no u_valid is produced.
- States: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> OUT -> IDLE.
  - busy = (state != IDLE), registered.
- IDLE:
  - If sample_valid: latch kp, ki, kd, setpoint, feedback into internal registers; go to ERR (edge E0).
  - Later gain changes do not affect the computation in flight.
  - If clear_integ: integ=0 and e_prev=0. When it coincides with sample_valid, the clear applies first and the new sample starts from zero history.
  - clear_integ outside IDLE is ignored.
- ERR (edge E1):
  - e = sat16(setpoint - feedback), computed at 17 bits.
  - integ = clamp(integ + e, -INTEG_LIM, +INTEG_LIM), computed at 17 bits.
  - d = sat16(e - e_prev).
  - e_prev = e.
- MUL_P (E2): acc = kp*e (signed 32-bit product, 34-bit accumulator).
- MUL_I (E3): acc += ki*integ.
- MUL_D (E4): acc += kd*d.
- OUT (E5):
  - u = sat16(acc >>> FRAC). Arithmetic shift, floor toward -inf; saturate to [-32768, 32767].
  - u_valid=1 for exactly one cycle, cleared at E6.
  - Return to IDLE.
- Latency: u_valid is visible 5 edges after the edge that accepted sample_valid. Minimum accept-to-accept spacing is 6 cycles.
- sample_valid while busy (including the OUT cycle) is dropped; there is no queueing.
- u holds its last value until the next OUT or reset.

Test Plan:
- P-only: kp=0x0100, ki=kd=0, setpoint=100, feedback=40 -> after 5 edges u=60, u_valid pulses exactly 1 cycle, busy high for 5 cycles.
- Integral: kp=kd=0, ki=0x0080, e=10 for three samples -> u=5, 10, 15.
- Derivative: after reset, kd=0x0100, kp=ki=0; e=10 then e=30 -> u=10, then 20. Then assert clear_integ in IDLE and repeat e=30 -> u=30.
- Saturation: kp=0x7FFF, setpoint=32767, feedback=-32768 -> e clamps to 32767, u=32767. Negated case (setpoint=-32768, feedback=32767) -> u=-32768.
- Integrator clamp: ki=0x0100, kp=kd=0, e=5000 twice -> u=5000, then 8192 (integ held at INTEG_LIM).
- Busy/reset: sample_valid at E0 and again at E2 -> only one u_valid. Separately, reset asserted at E3 -> u=0, u_valid never pulses, busy=0, and the next sample is computed with integ=0.
